// File: rtl/hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | hazard_ctrl: RAW scoreboard, stall/flush sequencing and HALT drain   |
// | for the 5-stage core.                          Revision: 1.0         |
// +---------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        wb_w,
  input  logic [4:0]  wb_addr,
  input  logic        ex_branch_taken,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        issue,
  output logic        halted,
  output logic [31:0] stall_cycles
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  localparam logic [5:0] OP_IALU_LAST = 6'h0B;
  localparam logic [5:0] OP_LDW       = 6'h0C;
  localparam logic [5:0] OP_STW       = 6'h0D;
  localparam logic [5:0] OP_BZ        = 6'h0E;
  localparam logic [5:0] OP_BEQ       = 6'h0F;
  localparam logic [5:0] OP_JR        = 6'h10;
  localparam logic [5:0] OP_HALT      = 6'h11;

  logic [1:0]                     state_q, state_d;
  logic [DRAIN_W-1:0]             drain_q, drain_d;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]                    stall_cycles_q, stall_cycles_d;

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd, dest;
  logic       use_rs, use_rt, is_halt;

  assign opcode = id_inst[31:26];
  assign rs     = id_inst[25:21];
  assign rt     = id_inst[20:16];
  assign rd     = id_inst[15:11];

  // Even opcodes up to 0x0A are R-type, odd ones up to 0x0B are I-ALU.
  always_comb begin
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_halt = 1'b0;
    dest    = '0;
    if (opcode <= OP_IALU_LAST) begin
      use_rs = 1'b1;
      if (!opcode[0]) begin
        use_rt = 1'b1;
        dest   = rd;
      end else begin
        dest = rt;
      end
    end else begin
      case (opcode)
        OP_LDW: begin
          use_rs = 1'b1;
          dest   = rt;
        end
        OP_STW, OP_BEQ: begin
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        OP_BZ, OP_JR: use_rs = 1'b1;
        OP_HALT:      is_halt = 1'b1;
        default:      ;
      endcase
    end
  end

  logic [NUM_REGS-1:0] pend;
  logic                any_pend;
  logic                hazard;

  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
      assign pend[r] = |cnt_q[r];
    end
  endgenerate

  assign any_pend = |pend;
  // A saturated dest counter also stalls so the counter can never wrap.
  assign hazard = (use_rs && (rs != 5'd0) && pend[rs]) ||
                  (use_rt && (rt != 5'd0) && pend[rt]) ||
                  ((dest != 5'd0) && (cnt_q[dest] == CNT_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (issue && is_halt) state_d = ST_DRAIN;
      ST_DRAIN: if (!any_pend && (drain_q <= DRAIN_W'(1))) state_d = ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    issue       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          flush_if_id = 1'b1;
          bubble_ex   = 1'b1;
        end else if (id_valid) begin
          if (hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        bubble_ex   = 1'b1;
        flush_if_id = ex_branch_taken;
      end
      default: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    endcase
  end

  assign halted = (state_q == ST_HALTED);

  // Drain counter restarts whenever a write is still outstanding.
  always_comb begin
    drain_d = drain_q;
    if ((state_q == ST_RUN) && issue && is_halt) begin
      drain_d = DRAIN_LOAD;
    end else if (state_q == ST_DRAIN) begin
      if (any_pend) begin
        drain_d = DRAIN_LOAD;
      end else if (drain_q != '0) begin
        drain_d = drain_q - DRAIN_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if ((issue && (dest == 5'(r))) && !(wb_w && (wb_addr == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if ((wb_w && (wb_addr == 5'(r))) && !(issue && (dest == 5'(r))) &&
                   (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_id && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_q        <= '0;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      drain_q        <= drain_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_hazard_ctrl: directed vectors against a cycle model of the        |
// | hazard controller.                             Revision: 1.0         |
// +---------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 2;
  localparam int CNT_MAXV     = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        wb_w;
  logic [4:0]  wb_addr;
  logic        ex_branch_taken;
  logic        stall_if, stall_id, bubble_ex, flush_if_id, issue, halted;
  logic [31:0] stall_cycles;

  hazard_ctrl #(
    .NUM_REGS    (32),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .wb_w           (wb_w),
    .wb_addr        (wb_addr),
    .ex_branch_taken(ex_branch_taken),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .bubble_ex      (bubble_ex),
    .flush_if_id    (flush_if_id),
    .issue          (issue),
    .halted         (halted),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: pending-write count per register, mode 0=run 1=drain 2=halted,
  // and a count of consecutive empty-scoreboard cycles spent draining.
  int     m_cnt [32];
  int     m_mode;
  int     m_empty_run;
  longint m_stalls;
  logic   e_stall_if, e_stall_id, e_bubble, e_flush, e_issue;
  int     e_dst;
  bit     e_halt;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_mode      = 0;
    m_empty_run = 0;
    m_stalls    = 0;
  endtask

  task automatic model_eval();
    int op, rs, rt, rd;
    bit urs, urt, haz;
    op = int'(id_inst[31:26]);
    rs = int'(id_inst[25:21]);
    rt = int'(id_inst[20:16]);
    rd = int'(id_inst[15:11]);
    urs = 0; urt = 0; e_dst = 0; e_halt = 0;
    if (op <= 11) begin
      urs = 1;
      if (op % 2 == 0) begin urt = 1; e_dst = rd; end
      else e_dst = rt;
    end else if (op == 12) begin urs = 1; e_dst = rt; end
    else if (op == 13 || op == 15) begin urs = 1; urt = 1; end
    else if (op == 14 || op == 16) urs = 1;
    else if (op == 17) e_halt = 1;
    haz = (urs && rs != 0 && m_cnt[rs] != 0) || (urt && rt != 0 && m_cnt[rt] != 0) ||
          (e_dst != 0 && m_cnt[e_dst] == CNT_MAXV);
    e_stall_if = 0; e_stall_id = 0; e_bubble = 0; e_flush = 0; e_issue = 0;
    if (m_mode == 0) begin
      e_flush    = ex_branch_taken;
      e_issue    = id_valid && !haz && !ex_branch_taken;
      e_stall_id = id_valid && haz && !ex_branch_taken;
      e_stall_if = e_stall_id;
      e_bubble   = e_stall_id || ex_branch_taken;
    end else begin
      e_stall_if = 1; e_stall_id = 1; e_bubble = 1;
      e_flush    = (m_mode == 1) ? ex_branch_taken : 1'b0;
    end
  endtask

  task automatic model_step();
    bit empty, inc, dec;
    empty = 1;
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) empty = 0;
    if (m_mode == 0) begin
      if (e_issue && e_halt) begin m_mode = 1; m_empty_run = 0; end
    end else if (m_mode == 1) begin
      if (empty) begin
        m_empty_run++;
        if (m_empty_run >= DRAIN_CYCLES) m_mode = 2;
      end else m_empty_run = 0;
    end
    inc = e_issue && e_dst != 0;
    dec = wb_w && wb_addr != 5'd0;
    if (inc && dec && e_dst == int'(wb_addr)) begin
      // net unchanged
    end else begin
      if (inc) m_cnt[e_dst]++;
      if (dec && m_cnt[wb_addr] > 0) m_cnt[wb_addr]--;
    end
    if (e_stall_id && m_stalls < 64'hFFFF_FFFF) m_stalls++;
  endtask

  always @(negedge clk) begin
    if (!reset) model_reset();
    model_eval();
    chk("m_stall_if", 32'(stall_if), 32'(e_stall_if));
    chk("m_stall_id", 32'(stall_id), 32'(e_stall_id));
    chk("m_bubble_ex", 32'(bubble_ex), 32'(e_bubble));
    chk("m_flush_if_id", 32'(flush_if_id), 32'(e_flush));
    chk("m_issue", 32'(issue), 32'(e_issue));
    chk("m_halted", 32'(halted), 32'(m_mode == 2));
    chk("m_stall_cycles", stall_cycles, 32'(m_stalls));
    if (reset) model_step();
  end

  function automatic logic [31:0] r_inst(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs);
    return {op, rs, rt, 16'd0};
  endfunction

  localparam logic [31:0] HALT_I = {6'h11, 26'd0};

  task automatic drive(input logic v, input logic [31:0] inst, input logic w,
                       input logic [4:0] a, input logic br);
    id_valid = v; id_inst = inst; wb_w = w; wb_addr = a; ex_branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected finish before t=20000");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(0, 32'd0, 0, 5'd0, 0);
    tick(); tick();
    chk("rst_stall_if", 32'(stall_if), 0);
    chk("rst_bubble", 32'(bubble_ex), 0);
    chk("rst_issue", 32'(issue), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    reset = 1'b1;
    tick();

    // add r3,r1,r2 then add r4,r3,r5: three stall cycles before issue
    drive(1, r_inst(6'h00, 5'd3, 5'd1, 5'd2), 0, 5'd0, 0);
    chk("add_r3_issue", 32'(issue), 1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1, r_inst(6'h00, 5'd4, 5'd3, 5'd5), c == 3, 5'd3, 0);
      chk("raw_stall_id", 32'(stall_id), 1);
      chk("raw_bubble", 32'(bubble_ex), 1);
      tick();
    end
    drive(1, r_inst(6'h00, 5'd4, 5'd3, 5'd5), 0, 5'd0, 0);
    chk("raw_issue", 32'(issue), 1);
    chk("raw_stall_count", stall_cycles, 3);
    tick();

    // taken branch overrides a hazard stall; a flushed HALT is ignored
    drive(1, r_inst(6'h00, 5'd6, 5'd4, 5'd1), 0, 5'd0, 0);
    chk("pre_br_stall", 32'(stall_id), 1);
    tick();
    drive(1, r_inst(6'h00, 5'd6, 5'd4, 5'd1), 0, 5'd0, 1);
    chk("br_flush", 32'(flush_if_id), 1);
    chk("br_no_stall_if", 32'(stall_if), 0);
    chk("br_no_issue", 32'(issue), 0);
    tick();
    drive(1, HALT_I, 0, 5'd0, 1);
    chk("halt_flushed", 32'(issue), 0);
    tick();
    drive(0, 32'd0, 0, 5'd0, 0);
    chk("no_drain_after_flush", 32'(stall_if), 0);
    tick();
    drive(0, 32'd0, 1, 5'd4, 0);
    tick();
    drive(1, r_inst(6'h00, 5'd6, 5'd4, 5'd1), 0, 5'd0, 0);
    chk("r4_cleared_issue", 32'(issue), 1);
    tick();

    // three writes to r7 saturate its counter
    for (int k = 0; k < 3; k++) begin
      drive(1, i_inst(6'h0C, 5'd7, 5'd1), 0, 5'd0, 0);
      chk("ldw_r7_issue", 32'(issue), 1);
      tick();
    end
    drive(1, i_inst(6'h01, 5'd7, 5'd1), 0, 5'd0, 0);
    chk("dest_sat_stall", 32'(stall_id), 1);
    tick();
    drive(1, i_inst(6'h01, 5'd7, 5'd1), 1, 5'd7, 0);
    chk("sat_no_bypass", 32'(stall_id), 1);
    tick();
    drive(1, i_inst(6'h01, 5'd7, 5'd1), 0, 5'd0, 0);
    chk("sat_release", 32'(issue), 1);
    tick();
    drive(1, r_inst(6'h00, 5'd0, 5'd1, 5'd2), 0, 5'd0, 0);
    chk("r0_writer_issue", 32'(issue), 1);
    tick();
    drive(1, r_inst(6'h02, 5'd8, 5'd0, 5'd0), 0, 5'd0, 0);
    chk("r0_reader_issue", 32'(issue), 1);
    tick();
    drive(0, 32'd0, 1, 5'd9, 0);
    tick();
    drive(1, i_inst(6'h03, 5'd10, 5'd9), 0, 5'd0, 0);
    chk("r9_no_underflow", 32'(issue), 1);
    tick();

    // issue and WB to r5 in the same cycle leave one write pending
    drive(1, i_inst(6'h05, 5'd5, 5'd1), 0, 5'd0, 0);
    chk("r5_first_issue", 32'(issue), 1);
    tick();
    drive(1, i_inst(6'h05, 5'd5, 5'd1), 1, 5'd5, 0);
    chk("r5_second_issue", 32'(issue), 1);
    tick();
    drive(1, r_inst(6'h00, 5'd11, 5'd5, 5'd1), 0, 5'd0, 0);
    chk("r5_still_pending", 32'(stall_id), 1);
    tick();
    drive(0, 32'd0, 1, 5'd5, 0);
    tick();
    drive(1, r_inst(6'h00, 5'd11, 5'd5, 5'd1), 0, 5'd0, 0);
    chk("r5_cleared", 32'(issue), 1);
    tick();

    for (int r = 1; r < 32; r++) begin
      for (int k = 0; k < 4 && m_cnt[r] != 0; k++) begin
        drive(0, 32'd0, 1, 5'(r), 0);
        tick();
      end
    end

    // HALT with an LDW to r2 in flight
    drive(1, i_inst(6'h0C, 5'd2, 5'd1), 0, 5'd0, 0);
    chk("ldw_r2_issue", 32'(issue), 1);
    tick();
    drive(1, HALT_I, 0, 5'd0, 0);
    chk("halt_issue", 32'(issue), 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 32'd0, 0, 5'd0, 0);
      chk("drain_stall_if", 32'(stall_if), 1);
      chk("drain_not_halted", 32'(halted), 0);
      tick();
    end
    drive(0, 32'd0, 1, 5'd2, 0);
    tick();
    for (int c = 1; c <= DRAIN_CYCLES; c++) begin
      drive(0, 32'd0, 0, 5'd0, 0);
      chk("drain_wait", 32'(halted), 0);
      tick();
    end
    drive(0, 32'd0, 0, 5'd0, 0);
    chk("halted_set", 32'(halted), 1);
    tick();
    drive(1, r_inst(6'h00, 5'd3, 5'd1, 5'd2), 0, 5'd0, 1);
    chk("halted_ignores_br", 32'(flush_if_id), 0);
    chk("halted_no_issue", 32'(issue), 0);
    chk("halted_stall_id", 32'(stall_id), 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 32'd0, 0, 5'd0, 0);
      chk("halted_sticky", 32'(halted), 1);
      tick();
    end

    // async reset out of HALTED
    drive(0, 32'd0, 0, 5'd0, 0);
    reset = 1'b0;
    #1;
    chk("rst_from_halted", 32'(halted), 0);
    chk("rst_stall_cycles_clr", stall_cycles, 0);
    tick();
    reset = 1'b1;
    tick();

    // async reset mid-DRAIN
    drive(1, i_inst(6'h0C, 5'd2, 5'd1), 0, 5'd0, 0);
    tick();
    drive(1, HALT_I, 0, 5'd0, 0);
    chk("halt2_issue", 32'(issue), 1);
    tick();
    drive(0, 32'd0, 0, 5'd0, 0);
    chk("drain2_stall", 32'(stall_if), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_drain_stall_if", 32'(stall_if), 0);
    chk("rst_mid_drain_halted", 32'(halted), 0);
    tick();
    reset = 1'b1;
    tick();
    drive(1, r_inst(6'h00, 5'd3, 5'd2, 5'd1), 0, 5'd0, 0);
    chk("run_after_reset", 32'(issue), 1);
    tick();
    drive(0, 32'd0, 0, 5'd0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB core. Keeps a per-register scoreboard of in-flight writes, stalls IF and ID with an EX bubble on read-after-write hazards, flushes IF/ID on a taken branch, and drains the pipe into a terminal halted state on HALT. Sits beside the ID stage. Consumes the raw instruction in ID, the WB write port and the EX branch resolution. Drives the stall, bubble and flush controls of the pipeline registers.

## Interface
- NUM_REGS, 32, architectural register count; register 0 is hard zero.
- DRAIN_CYCLES, 3, cycles to wait after the scoreboard empties before entering HALTED.
- CNT_W, 2, width of each per-register pending counter.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID stage holds a valid instruction.
- id_inst  in  32  instruction in ID: opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
- wb_w  in  1  WB writes the register file this cycle.
- wb_addr  in  5  WB destination register.
- ex_branch_taken  in  1  branch/JR resolved taken in EX this cycle.
- stall_if  out  1  hold PC and the IF/ID register.
- stall_id  out  1  hold the ID instruction (do not advance).
- bubble_ex  out  1  load a NOP (all controls 0) into ID/EX.
- flush_if_id  out  1  squash the IF/ID contents.
- issue  out  1  ID instruction advances to EX this cycle.
- halted  out  1  core halted; reset is the only exit.
- stall_cycles  out  32  saturating count of cycles with stall_id=1.

## Operation
- Decode, opcode groups:
  - R-type 0x00,0x02,0x04,0x06,0x08,0x0A: src rs, rt; dest rd.
  - I-ALU 0x01,0x03,0x05,0x07,0x09,0x0B: src rs; dest rt.
  - LDW 0x0C: src rs; dest rt.
  - STW 0x0D: src rs, rt; no dest.
  - BZ 0x0E: src rs. BEQ 0x0F: src rs, rt. JR 0x10: src rs. None of these have a dest.
  - HALT 0x11, and any other opcode: no src, no dest.
- Register 0 is never a hazard source and is never scoreboarded.
- Scoreboard: one CNT_W-bit pending counter per register.
  - Issue with dest≠0: increment that dest's counter.
  - wb_w=1 with wb_addr≠0: decrement that counter.
  - Both events on the same register in the same cycle: net unchanged.
  - Decrement at 0 is ignored (no underflow).
- Hazard when either:
  - any used source has counter≠0, or
  - the dest counter equals max (2^CNT_W-1).
- issue = id_valid & state RUN & !hazard & !ex_branch_taken.
- Stall/bubble in RUN: when id_valid & hazard & !ex_branch_taken, assert stall_if, stall_id and bubble_ex.
- Flush: ex_branch_taken asserts flush_if_id and bubble_ex. The ID instruction is not issued (no scoreboard update). Flush overrides stall: stall_if=stall_id=0.
- State machine:
  - RUN → DRAIN when a HALT issues. The HALT itself is not scoreboarded.
  - DRAIN: stall_if=stall_id=bubble_ex=1; issue=0; the drain counter loads DRAIN_CYCLES on every cycle any scoreboard counter ≠0.
  - DRAIN → HALTED when all counters are 0 and the drain counter reaches 0 (decrements once per cycle).
  - HALTED: stall_if=stall_id=bubble_ex=1; halted=1; ex_branch_taken is ignored (flush_if_id=0). WB decrements still apply.
- A HALT in ID while ex_branch_taken=1 is flushed and does not enter DRAIN.
- stall_cycles increments on each cycle with stall_id=1 and saturates at 0xFFFF_FFFF.

## Timing
- stall_if, stall_id, bubble_ex, flush_if_id and issue are combinational from the inputs and current state. No added latency.
- Scoreboard, state, drain counter and stall_cycles update on posedge clk.
- A WB write at edge N clears the hazard for an ID consumer from cycle N+1; there is no WB→ID same-cycle bypass.
- Dependent back-to-back R-types, e.g. add r3 then add r4←r3: 3 stall cycles (EX, MEM, WB occupancy).
- Reset asserted (low), asynchronously: all counters 0, state RUN, drain counter 0, halted=0, stall_cycles=0.
  - This includes reset mid-DRAIN or mid-stall.
  - With id_valid=0 and ex_branch_taken=0, all combinational outputs are 0.
- Release is synchronous to the next posedge.

## Test plan
- Reset with id_valid=0: all outputs 0. Then issue add r3,r1,r2 (r1/r2 clean) → issue=1 that cycle; cnt[3]=1 next cycle.
- RAW: add r3 issued at cycle 0, then add r4,r3,r5 in ID; WB r3 at the end of cycle 3 → stall_id=bubble_ex=1 for cycles 1–3, issue=1 in cycle 4, stall_cycles=3.
- Branch flush: hazard stall active and ex_branch_taken=1 → flush_if_id=1, stall_if=0, no scoreboard change; a HALT in ID in the same cycle does not enter DRAIN.
- Saturation/zero: three in-flight writes to r7 (cnt=3) then addi r7 in ID → hazard stall until a WB to r7. A writer to r0 never stalls anything. A WB to r9 with cnt=0 leaves it 0.
- Simultaneous: issue dest r5 plus WB r5 in the same cycle with cnt[5]=1 → cnt[5] stays 1.
- HALT drain: HALT issued with one LDW to r2 in flight → DRAIN until WB r2 and DRAIN_CYCLES more, then halted=1 and stays 1. Asserting reset mid-DRAIN returns to RUN with halted=0.
